// File: rtl/uart_fifo_tx_engine.sv
// UART transmit engine: reads one byte at a time from the TX FIFO and sends it
// as start bit, 7 or 8 data bits (LSB first), optional parity bit and one stop bit.
// Bit timing comes from a one-clock baud_en strobe at OVERSAMPLE x the baud rate.
module uart_fifo_tx_engine #(
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  baud_en,
  input  logic                  fifo_empty,
  input  logic [FIFO_WIDTH-1:0] fifo_data,
  output logic                  fifo_read_n,
  input  logic                  bit8,
  input  logic                  parity_en,
  input  logic                  odd_n_even,
  output logic                  tx,
  output logic                  tx_busy
);

  localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_READ   = 3'd1;
  localparam logic [2:0] ST_WAIT   = 3'd2;
  localparam logic [2:0] ST_LOAD   = 3'd3;
  localparam logic [2:0] ST_START  = 3'd4;
  localparam logic [2:0] ST_DATA   = 3'd5;
  localparam logic [2:0] ST_PARITY = 3'd6;
  localparam logic [2:0] ST_STOP   = 3'd7;

  logic [2:0]    state_r;
  logic [TW-1:0] tick_cnt_r;
  logic [2:0]    bit_cnt_r;
  logic [7:0]    shreg_r;
  logic          parity_r;
  logic          cfg_bit8_r;
  logic          cfg_parity_en_r;
  logic          tx_r;
  logic          read_n_r;
  logic          busy_r;

  logic          counting_s;
  logic          bit_end_s;
  logic [2:0]    bit_last_s;

  // Parity over the bits that actually go on the line; bit 7 only counts in 8-bit mode.
  function automatic logic calc_parity(input logic [7:0] data, input logic use_bit7,
                                       input logic odd);
    calc_parity = (^data[6:0]) ^ (use_bit7 & data[7]) ^ odd;
  endfunction

  assign tx          = tx_r;
  assign fifo_read_n = read_n_r;
  assign tx_busy     = busy_r;

  // Decode whether baud ticks are being counted and whether this tick closes a bit.
  always_comb begin
    counting_s = 1'b0;
    case (state_r)
      ST_START, ST_DATA, ST_PARITY, ST_STOP: counting_s = 1'b1;
      default:                               counting_s = 1'b0;
    endcase
    bit_end_s  = counting_s & baud_en & (tick_cnt_r == TICK_LAST);
    if (cfg_bit8_r) begin
      bit_last_s = 3'd7;
    end else begin
      bit_last_s = 3'd6;
    end
  end

  // Oversample tick counter: cleared on load, advances on baud_en while on the line.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt_r <= {TW{1'b0}};
    end else if (state_r == ST_LOAD) begin
      tick_cnt_r <= {TW{1'b0}};
    end else if (counting_s && baud_en) begin
      tick_cnt_r <= bit_end_s ? {TW{1'b0}} : (tick_cnt_r + TW'(1));
    end else begin
      tick_cnt_r <= tick_cnt_r;
    end
  end

  // Frame sequencer: FIFO handshake, byte/config capture and serial bit output.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r         <= ST_IDLE;
      bit_cnt_r       <= 3'd0;
      shreg_r         <= 8'd0;
      parity_r        <= 1'b0;
      cfg_bit8_r      <= 1'b0;
      cfg_parity_en_r <= 1'b0;
      tx_r            <= 1'b1;
      read_n_r        <= 1'b1;
      busy_r          <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (!fifo_empty) begin
            read_n_r <= 1'b0;
            busy_r   <= 1'b1;
            state_r  <= ST_READ;
          end else begin
            state_r  <= ST_IDLE;
          end
        end
        ST_READ: begin
          read_n_r <= 1'b1;
          state_r  <= ST_WAIT;
        end
        ST_WAIT: begin
          // FIFO output register needs this extra clock before the byte is valid.
          state_r <= ST_LOAD;
        end
        ST_LOAD: begin
          shreg_r         <= fifo_data[7:0];
          cfg_bit8_r      <= bit8;
          cfg_parity_en_r <= parity_en;
          parity_r        <= calc_parity(fifo_data[7:0], bit8, odd_n_even);
          tx_r            <= 1'b0;
          state_r         <= ST_START;
        end
        ST_START: begin
          if (bit_end_s) begin
            tx_r      <= shreg_r[0];
            bit_cnt_r <= 3'd0;
            state_r   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (bit_end_s) begin
            if (bit_cnt_r < bit_last_s) begin
              shreg_r   <= {1'b0, shreg_r[7:1]};
              tx_r      <= shreg_r[1];
              bit_cnt_r <= bit_cnt_r + 3'd1;
            end else if (cfg_parity_en_r) begin
              tx_r    <= parity_r;
              state_r <= ST_PARITY;
            end else begin
              tx_r    <= 1'b1;
              state_r <= ST_STOP;
            end
          end
        end
        ST_PARITY: begin
          if (bit_end_s) begin
            tx_r    <= 1'b1;
            state_r <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (bit_end_s) begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        default: begin
          tx_r     <= 1'b1;
          read_n_r <= 1'b1;
          busy_r   <= 1'b0;
          state_r  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_fifo_tx_engine.sv
// Bench for uart_fifo_tx_engine: a queue-style FIFO model feeds bytes, random
// baud strobes drive timing, and each frame on tx is compared bit by bit with a
// frame built from the byte and its configuration.
module tb_uart_fifo_tx_engine;

  localparam int OS = 16;

  logic       clock = 1'b0;
  logic       reset_n = 1'b1;
  logic       baud_en = 1'b0;
  logic       fifo_empty;
  logic [7:0] fifo_data = 8'h00;
  logic       fifo_read_n;
  logic       bit8 = 1'b1;
  logic       parity_en = 1'b0;
  logic       odd_n_even = 1'b0;
  logic       tx;
  logic       tx_busy;

  int n_checks = 0;
  int n_fail   = 0;
  int pushes   = 0;   // written only by the stimulus process
  int pops     = 0;   // written only by the FIFO model
  int reads    = 0;   // completed read pulses seen on fifo_read_n
  logic [7:0] mem [0:255];

  assign fifo_empty = (pushes == pops);

  uart_fifo_tx_engine #(.OVERSAMPLE(OS), .FIFO_WIDTH(8)) dut (
    .clock(clock), .reset_n(reset_n), .baud_en(baud_en),
    .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_read_n(fifo_read_n),
    .bit8(bit8), .parity_en(parity_en), .odd_n_even(odd_n_even),
    .tx(tx), .tx_busy(tx_busy)
  );

  initial forever #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Random one-clock baud strobes, about one clock in three.
  initial forever begin
    @(posedge clock);
    #1;
    baud_en = ($urandom_range(0, 2) == 0);
  end

  // FIFO model: a read strobe sampled low pops the next byte onto the output register.
  initial forever begin
    @(posedge clock);
    if (fifo_read_n === 1'b0) begin
      chk("read_while_empty", (pushes != pops), 1);
      #1;
      fifo_data = mem[pops % 256];
      pops++;
    end
  end

  // Read pulse width monitor: every low pulse must last exactly one clock.
  initial begin
    int run;
    run = 0;
    forever begin
      @(negedge clock);
      if (fifo_read_n === 1'b0) begin
        run++;
      end else if (run > 0) begin
        chk("read_pulse_width", run, 1);
        reads++;
        run = 0;
      end
    end
  end

  task automatic push(input logic [7:0] d);
    mem[pushes % 256] = d;
    pushes++;
  endtask

  task automatic set_cfg(input logic b8, input logic pe, input logic odd);
    bit8 = b8;
    parity_en = pe;
    odd_n_even = odd;
  endtask

  // Wait for a frame and compare every bit. exp_par < 0 means no hand-computed
  // parity value; exp_gap < 0 means the frame does not follow another directly.
  task automatic check_frame(input logic [7:0] d, input logic b8, input logic pe,
                             input logic odd, input int exp_par, input int exp_gap);
    logic bits [0:10];
    int   nb, k, ones, w, cnt, guard, par_idx;
    logic seen, obs_par;
    nb = b8 ? 8 : 7;
    k = 0;
    ones = 0;
    bits[k] = 1'b0; k++;
    for (int i = 0; i < nb; i++) begin
      bits[k] = d[i]; k++;
      ones += int'(d[i]);
    end
    par_idx = pe ? k : -1;
    if (pe) begin
      bits[k] = ((ones % 2) == 1) ^ odd; k++;
    end
    bits[k] = 1'b1; k++;
    obs_par = 1'b0;

    w = 0;
    do begin
      @(negedge clock);
      w++;
    end while (tx !== 1'b0 && w < 5000);
    chk($sformatf("start_seen_%02h", d), tx, 0);
    if (exp_gap >= 0) chk($sformatf("gap_before_%02h", d), w, exp_gap);
    // The engine has latched its config by now; scrambling it must not matter.
    set_cfg(1'($urandom), 1'($urandom), 1'($urandom));

    for (int j = 0; j < k; j++) begin
      cnt = 0;
      guard = 0;
      seen = bits[j];
      while (1) begin
        if (tx !== bits[j]) seen = tx;
        if (j == par_idx) obs_par = tx;
        if (baud_en) cnt++;
        @(negedge clock);
        guard++;
        if (cnt == OS || guard > 4000) break;
      end
      chk($sformatf("bit%0d_of_%02h", j, d), seen, bits[j]);
      chk($sformatf("bit%0d_ticks_%02h", j, d), cnt, OS);
    end
    set_cfg(b8, pe, odd);
    chk($sformatf("busy_after_stop_%02h", d), tx_busy, 0);
    chk($sformatf("tx_idle_after_stop_%02h", d), tx, 1);
    if (pe && exp_par >= 0) chk($sformatf("parity_bit_%02h", d), obs_par, exp_par[0]);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       b8;
    logic       pe;
    logic       odd;
    int         exp_par;
  } vec_t;

  vec_t tbl [0:24];

  initial begin
    int bad_rd, bad_tx, cnt, guard, reads_before;

    // Directed frames with hand-derived parity bits, then random frames.
    tbl[0] = '{8'hA5, 1'b1, 1'b0, 1'b0, -1};
    tbl[1] = '{8'h03, 1'b1, 1'b1, 1'b0, 0};
    tbl[2] = '{8'h03, 1'b1, 1'b1, 1'b1, 1};
    tbl[3] = '{8'h07, 1'b1, 1'b1, 1'b0, 1};
    tbl[4] = '{8'hFF, 1'b0, 1'b1, 1'b0, 1};
    for (int i = 5; i < 25; i++) begin
      tbl[i] = '{8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), -1};
    end

    #2 reset_n = 1'b0;
    #1;
    chk("reset_tx", tx, 1);
    chk("reset_read_n", fifo_read_n, 1);
    chk("reset_busy", tx_busy, 0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;

    // Empty FIFO: no read and an idle line for 1000 clocks.
    bad_rd = 0;
    bad_tx = 0;
    repeat (1000) begin
      @(negedge clock);
      if (fifo_read_n !== 1'b1) bad_rd++;
      if (tx !== 1'b1) bad_tx++;
    end
    chk("empty_no_read", bad_rd, 0);
    chk("empty_tx_idle", bad_tx, 0);

    for (int i = 0; i < 25; i++) begin
      set_cfg(tbl[i].b8, tbl[i].pe, tbl[i].odd);
      push(tbl[i].data);
      check_frame(tbl[i].data, tbl[i].b8, tbl[i].pe, tbl[i].odd, tbl[i].exp_par, -1);
    end

    // Back-to-back: three preloaded bytes, each frame 4 clocks after the last stop.
    set_cfg(1'b1, 1'b0, 1'b0);
    push(8'h11);
    push(8'h22);
    push(8'h33);
    check_frame(8'h11, 1'b1, 1'b0, 1'b0, -1, -1);
    check_frame(8'h22, 1'b1, 1'b0, 1'b0, -1, 4);
    check_frame(8'h33, 1'b1, 1'b0, 1'b0, -1, 4);

    // Random burst with parity, also back-to-back.
    begin
      logic [7:0] burst [0:3];
      logic       odd_b;
      odd_b = 1'($urandom);
      set_cfg(1'b1, 1'b1, odd_b);
      for (int i = 0; i < 4; i++) begin
        burst[i] = 8'($urandom);
        push(burst[i]);
      end
      for (int i = 0; i < 4; i++) begin
        check_frame(burst[i], 1'b1, 1'b1, odd_b, -1, (i == 0) ? -1 : 4);
      end
    end

    // Reset in the middle of data bit 3.
    set_cfg(1'b1, 1'b0, 1'b0);
    push(8'h5A);
    guard = 0;
    do begin
      @(negedge clock);
      guard++;
    end while (tx !== 1'b0 && guard < 5000);
    chk("rst_frame_started", tx, 0);
    cnt = 0;
    guard = 0;
    while (cnt < 4 * OS + OS / 2 && guard < 8000) begin
      if (baud_en) cnt++;
      @(negedge clock);
      guard++;
    end
    chk("rst_reached_bit3", cnt, 4 * OS + OS / 2);
    chk("rst_busy_before", tx_busy, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_async_tx", tx, 1);
    chk("rst_async_busy", tx_busy, 0);
    @(negedge clock);
    reset_n = 1'b1;
    reads_before = reads;
    bad_rd = 0;
    bad_tx = 0;
    repeat (200) begin
      @(negedge clock);
      if (fifo_read_n !== 1'b1) bad_rd++;
      if (tx !== 1'b1 || tx_busy !== 1'b0) bad_tx++;
    end
    chk("post_rst_no_read", bad_rd, 0);
    chk("post_rst_idle", bad_tx, 0);
    chk("post_rst_read_count", reads, reads_before);

    chk("total_reads", reads, pushes);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
